// File: rtl/cic_pkg.sv
// Shared constants and types for the CIC decimator feeding the ISOP
// compensator. The default N/R/IN_W/OUT_W values are also used by the ISOP bench.
package cic_pkg;

   localparam int CIC_N     = 4;
   localparam int CIC_R     = 8;
   localparam int CIC_IN_W  = 8;
   localparam int CIC_OUT_W = 8;

   // Internal register growth: B = IN_W + N*log2(R).
   function automatic int cic_width(input int in_w, input int n, input int r);
      return in_w + n * $clog2(r);
   endfunction

   localparam int CIC_B = cic_width(CIC_IN_W, CIC_N, CIC_R);

   // B-bit accumulator at the default configuration.
   typedef logic signed [CIC_B-1:0] cic_acc_t;

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream bundle of the CIC decimator.
// Handshake: there is no backpressure. d_in is taken on every rising clk edge
// where in_valid is 1. out_valid is a one-cycle strobe that marks a new d_out.
// d_out holds its value between strobes.
interface cic_decimator_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
);
   logic signed [IN_W-1:0]  d_in;
   logic                    in_valid;
   logic signed [OUT_W-1:0] d_out;
   logic                    out_valid;

   // Producer side of the stream; the bench uses this side.
   modport master (output d_in, output in_valid, input d_out, input out_valid);
   // Filter side of the stream.
   modport slave  (input d_in, input in_valid, output d_out, output out_valid);
endinterface

// File: rtl/cic_comb_stage.sv
// One registered CIC comb section (differential delay 1): y = x - x_delayed.
// The stage updates only when its valid token arrives. The token is forwarded
// one clock later.
module cic_comb_stage #(
   parameter int W = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] x,
   input  logic                vin,
   output logic signed [W-1:0] y,
   output logic                vout
);

   logic signed [W-1:0] dly;

   // Difference against the previous decimated value, then remember x.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dly  <= '0;
         y    <= '0;
         vout <= 1'b0;
      end else begin
         vout <= vin;
         if (vin) begin
            y   <= x - dly;
            dly <= x;
         end
      end
   end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (differential delay 1, decimation R) that feeds ISOP.
// Integrators run at the input rate. The combs run once per R accepted samples
// as a valid-token pipeline. d_out is the top OUT_W bits of the final comb,
// which gives unity DC gain.
// Optional build macro CIC_ROUND_EN: round half-up before truncation and
// saturate on positive overflow. When it is undefined, plain truncation is used.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int N     = CIC_N,
   parameter int R     = CIC_R,
   parameter int IN_W  = CIC_IN_W,
   parameter int OUT_W = CIC_OUT_W
) (
   input  logic            clk,
   input  logic            rst,
   cic_decimator_if.slave  bus
);

   localparam int B  = cic_width(IN_W, N, R);
   localparam int CW = $clog2(R);

   typedef logic signed [B-1:0] acc_t;

   if ((R < 2) || ((R & (R - 1)) != 0)) begin : g_bad_r
      $error("cic_decimator: R must be a power of two and at least 2");
   end

   acc_t                    integ [N];
   logic [CW-1:0]           count;
   logic                    block_done;
   acc_t                    dec;
   logic                    dec_valid;
   acc_t                    stage_x    [N];
   logic                    stage_vin  [N];
   acc_t                    stage_y    [N];
   logic                    stage_vout [N];
   acc_t                    final_comb;
   logic                    final_valid;
   logic signed [OUT_W-1:0] out_next;
   logic signed [OUT_W-1:0] d_out_q;
   logic                    out_valid_q;

   // Integrator cascade. Stage k adds the pre-edge value of stage k-1.
   // Wrap-around modulo 2^B is intended and cancels in the combs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) integ[k] <= '0;
      end else if (bus.in_valid) begin
         integ[0] <= integ[0] + {{(B-IN_W){bus.d_in[IN_W-1]}}, bus.d_in};
         for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end
   end

   // Count accepted samples. Flag the edge that takes the R-th sample of a block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         block_done <= 1'b0;
      end else begin
         block_done <= bus.in_valid && (count == CW'(R - 1));
         if (bus.in_valid) count <= count + 1'b1;
      end
   end

   // One edge after a block completes, capture the last integrator and start
   // the comb token.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec       <= '0;
         dec_valid <= 1'b0;
      end else begin
         dec_valid <= block_done;
         if (block_done) dec <= integ[N-1];
      end
   end

   // Chain the comb stages: each stage takes the previous stage's output and token.
   always_comb begin
      stage_x[0]   = dec;
      stage_vin[0] = dec_valid;
      for (int k = 1; k < N; k++) begin
         stage_x[k]   = stage_y[k-1];
         stage_vin[k] = stage_vout[k-1];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_comb
      cic_comb_stage #(.W(B)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .x    (stage_x[k]),
         .vin  (stage_vin[k]),
         .y    (stage_y[k]),
         .vout (stage_vout[k])
      );
   end

   assign final_comb  = stage_y[N-1];
   assign final_valid = stage_vout[N-1];

`ifdef CIC_ROUND_EN
   localparam logic [B:0] HALF = {{(OUT_W+1){1'b0}}, 1'b1, {(B-OUT_W-1){1'b0}}};

   logic [B:0] rnd_sum;
   logic       unused_rnd_low;

   assign rnd_sum        = {final_comb[B-1], final_comb} + HALF;
   assign unused_rnd_low = ^rnd_sum[B-OUT_W-1:0];

   // Round half-up. Only a positive overflow is possible, so clamp to the maximum.
   always_comb begin
      out_next = rnd_sum[B-1:B-OUT_W];
      if (rnd_sum[B] != rnd_sum[B-1]) out_next = {1'b0, {(OUT_W-1){1'b1}}};
   end
`else
   logic unused_trunc_low;

   assign unused_trunc_low = ^final_comb[B-OUT_W-1:0];

   // Truncate: keep the top OUT_W bits of the final comb.
   always_comb begin
      out_next = final_comb[B-1:B-OUT_W];
   end
`endif

   // Output register. d_out changes only together with the strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= final_valid;
         if (final_valid) d_out_q <= out_next;
      end
   end

   assign bus.d_out     = d_out_q;
   assign bus.out_valid = out_valid_q;

endmodule
